// File: rtl/wrapping_pointer_fifo_pkg.sv
// Shared helpers for the wrapping-pointer FIFO: power-of-two detection used to
// select the pointer wrap logic.
package wrapping_pointer_fifo_pkg;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/wrapping_lap_counter.sv
// Index counter over 0..RANGE-1 that toggles a lap bit every time it wraps,
// so two counters can be compared to tell "caught up" from "lapped".
module wrapping_lap_counter
  import wrapping_pointer_fifo_pkg::*;
#(
  parameter int RANGE      = 5,
  parameter int RANGE_LOG2 = $clog2(RANGE)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  increment,
  output logic [RANGE_LOG2-1:0] count,
  output logic                  lap
);

  logic [RANGE_LOG2-1:0] count_r;
  logic                  lap_r;
  logic                  at_max_s;

  // A power-of-two range rolls over by itself; others need the explicit compare.
  generate
    if (is_pow2(RANGE)) begin : g_pow2
      assign at_max_s = &count_r;
    end else begin : g_npow2
      assign at_max_s = (count_r == RANGE_LOG2'(RANGE - 1));
    end
  endgenerate

  // Index and lap state, advanced on each accepted increment.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_r <= {RANGE_LOG2{1'b0}};
      lap_r   <= 1'b0;
    end else if (increment) begin
      if (at_max_s) begin
        count_r <= {RANGE_LOG2{1'b0}};
        lap_r   <= ~lap_r;
      end else begin
        count_r <= count_r + {{(RANGE_LOG2-1){1'b0}}, 1'b1};
      end
    end
  end

  assign count = count_r;
  assign lap   = lap_r;

endmodule

// File: rtl/wrapping_pointer_fifo.sv
// Single-clock first-word-fall-through FIFO of any depth built on lap-bit pointers.
// Optional overflow/underflow pulses: define WRAPPING_POINTER_FIFO_ERROR_FLAGS_EN.
module wrapping_pointer_fifo
  import wrapping_pointer_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 5,
  parameter int DEPTH_LOG2 = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  write_enable,
  input  logic [WIDTH-1:0]      write_data,
  output logic                  full,
  input  logic                  read_enable,
  output logic [WIDTH-1:0]      read_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
`ifdef WRAPPING_POINTER_FIFO_ERROR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int                LEVEL_W     = DEPTH_LOG2 + 1;
  localparam logic [LEVEL_W-1:0] DEPTH_LEVEL = LEVEL_W'(DEPTH);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] write_index_s;
  logic [DEPTH_LOG2-1:0] read_index_s;
  logic                  write_lap_s;
  logic                  read_lap_s;
  logic                  index_equal_s;
  logic                  lap_differ_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  write_accept_s;
  logic                  read_accept_s;

  wrapping_lap_counter #(
    .RANGE      (DEPTH),
    .RANGE_LOG2 (DEPTH_LOG2)
  ) u_write_ptr (
    .clock     (clock),
    .resetn    (resetn),
    .increment (write_accept_s),
    .count     (write_index_s),
    .lap       (write_lap_s)
  );

  wrapping_lap_counter #(
    .RANGE      (DEPTH),
    .RANGE_LOG2 (DEPTH_LOG2)
  ) u_read_ptr (
    .clock     (clock),
    .resetn    (resetn),
    .increment (read_accept_s),
    .count     (read_index_s),
    .lap       (read_lap_s)
  );

  assign index_equal_s  = (write_index_s == read_index_s);
  assign lap_differ_s   = (write_lap_s != read_lap_s);
  assign empty_s        = index_equal_s && !lap_differ_s;
  assign full_s         = index_equal_s && lap_differ_s;
  assign write_accept_s = write_enable && !full_s;
  assign read_accept_s  = read_enable && !empty_s;

  // Storage is deliberately unreset; the pointers alone define valid contents.
  always_ff @(posedge clock) begin
    if (write_accept_s) begin
      mem_r[write_index_s] <= write_data;
    end
  end

  assign full      = full_s;
  assign empty     = empty_s;
  assign read_data = mem_r[read_index_s];
  // Modular subtraction; adding DEPTH when lapped folds the negative result back.
  assign level     = {1'b0, write_index_s} - {1'b0, read_index_s}
                   + (lap_differ_s ? DEPTH_LEVEL : {LEVEL_W{1'b0}});

`ifdef WRAPPING_POINTER_FIFO_ERROR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // One-cycle pulses for requests that were refused.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= write_enable && full_s;
      underflow_r <= read_enable && empty_s;
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

endmodule
